// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port among NUM_REQ
// valid/ready requesters, with optional burst lock and a registered write stage.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state_r, state_s;
  logic [ID_WIDTH-1:0]   ptr_r, ptr_s, owner_r, owner_s, grant_id_s, winner_s;
  logic [CNT_W-1:0]      beat_cnt_r, beat_cnt_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic                  wr_en_s, busy_s, can_issue_s, found_s;

  function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] idx);
    return (int'(idx) >= NUM_REQ - 1) ? {ID_WIDTH{1'b0}} : idx + ID_WIDTH'(1);
  endfunction

  // The beat already in the write register still lands, so almost_full blocks a new issue.
  assign can_issue_s = !fifo_full && !(fifo_wr_en && fifo_almost_full);
  assign req_ready   = rst_n ? ready_s : {NUM_REQ{1'b0}};

  // Round-robin winner: first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    found_s  = 1'b0;
    winner_s = {ID_WIDTH{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx      = (int'(ptr_r) + k) % NUM_REQ;
      winner_s = req_valid[idx] ? ID_WIDTH'(idx) : winner_s;
      found_s  = found_s | req_valid[idx];
    end
  end

  // Next-state, handshake and write-stage decode.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    beat_cnt_s = beat_cnt_r;
    busy_s     = busy;
    ready_s    = {NUM_REQ{1'b0}};
    wr_en_s    = 1'b0;
    wr_data_s  = fifo_wr_data;
    grant_id_s = grant_id;
    case (state_r)
      IDLE: begin
        if (can_issue_s && found_s) begin
          ready_s[winner_s] = 1'b1;
          wr_en_s           = 1'b1;
          wr_data_s         = req_data[winner_s*DATA_WIDTH +: DATA_WIDTH];
          grant_id_s        = winner_s;
          beat_cnt_s        = CNT_W'(1);
          if (MAX_BURST == 1) begin
            ptr_s = next_idx(winner_s);
          end else begin
            owner_s = winner_s;
            busy_s  = 1'b1;
            state_s = BURST;
          end
        end else begin
          ready_s = {NUM_REQ{1'b0}};
        end
      end
      BURST: begin
        if (!req_valid[owner_r]) begin
          state_s = IDLE;
          ptr_s   = next_idx(owner_r);
          busy_s  = 1'b0;
        end else if (can_issue_s) begin
          ready_s[owner_r] = 1'b1;
          wr_en_s          = 1'b1;
          wr_data_s        = req_data[owner_r*DATA_WIDTH +: DATA_WIDTH];
          grant_id_s       = owner_r;
          beat_cnt_s       = beat_cnt_r + CNT_W'(1);
          if (beat_cnt_r + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
            state_s = IDLE;
            ptr_s   = next_idx(owner_r);
            busy_s  = 1'b0;
          end else begin
            state_s = BURST;
          end
        end else begin
          state_s = BURST;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, pointer and registered write-stage outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ptr_r        <= {ID_WIDTH{1'b0}};
      owner_r      <= {ID_WIDTH{1'b0}};
      beat_cnt_r   <= {CNT_W{1'b0}};
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= {DATA_WIDTH{1'b0}};
      grant_id     <= {ID_WIDTH{1'b0}};
      busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      owner_r      <= owner_s;
      beat_cnt_r   <= beat_cnt_s;
      fifo_wr_en   <= wr_en_s;
      fifo_wr_data <= wr_data_s;
      grant_id     <= grant_id_s;
      busy         <= busy_s;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a burst-locked instance and a per-beat instance
// share requester stimulus; each has its own FIFO occupancy model.
module tb_fifo_wr_arbiter;
  localparam int NR = 4, DW = 8, IW = 2, DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic full_a = 1'b0, afull_a = 1'b0, full_b = 1'b0, afull_b = 1'b0;
  logic [NR-1:0] ready_a, ready_b;
  logic          wr_en_a, wr_en_b, busy_a, busy_b;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic [IW-1:0] gid_a, gid_b;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4), .ID_WIDTH(IW)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_a), .fifo_full(full_a), .fifo_almost_full(afull_a),
    .fifo_wr_en(wr_en_a), .fifo_wr_data(wr_data_a), .grant_id(gid_a), .busy(busy_a));

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1), .ID_WIDTH(IW)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_b), .fifo_full(full_b), .fifo_almost_full(afull_b),
    .fifo_wr_en(wr_en_b), .fifo_wr_data(wr_data_b), .grant_id(gid_b), .busy(busy_b));

  int passed = 0, total = 0;
  int mb[2] = '{4, 1};
  // Reference: owner < 0 means no burst lock is held.
  int m_ptr[2], m_owner[2], m_beats[2], m_gid[2], m_cnt[2], wr_cnt[2];
  bit m_wr_en[2], m_busy[2];
  logic [DW-1:0] m_data[2];
  int rd_mode = 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else passed++;
  endtask

  function automatic logic [NR*DW-1:0] lane(input int idx, input logic [DW-1:0] val);
    logic [NR*DW-1:0] r;
    r = '0;
    r[idx*DW +: DW] = val;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_owner[i] = -1; m_beats[i] = 0; m_gid[i] = 0; m_cnt[i] = 0;
      m_wr_en[i] = 1'b0; m_busy[i] = 1'b0; m_data[i] = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready_a"}, ready_a, 0);
    check_eq({tag, "_ready_b"}, ready_b, 0);
    check_eq({tag, "_wr_en"}, {wr_en_a, wr_en_b}, 0);
    check_eq({tag, "_busy"}, {busy_a, busy_b}, 0);
    check_eq({tag, "_gid"}, {gid_a, gid_b}, 0);
    check_eq({tag, "_data"}, {wr_data_a, wr_data_b}, 0);
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    req_valid = '1;
    full_a = 1'b0; afull_a = 1'b0; full_b = 1'b0; afull_b = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_reset_outputs("rst");
    req_valid = '0;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: drive at negedge, check ready, step reference, check registered outputs.
  task automatic cycle(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input bit ff);
    bit full[2], afull[2], rd[2], can;
    int g;
    logic [NR-1:0] er;
    req_valid = v;
    req_data  = d;
    for (int i = 0; i < 2; i++) begin
      full[i]  = ff || (m_cnt[i] == DEPTH);
      afull[i] = (m_cnt[i] >= DEPTH - 1);
      rd[i]    = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(0, 1) == 1);
    end
    full_a = full[0]; afull_a = afull[0]; full_b = full[1]; afull_b = afull[1];
    #1;
    for (int i = 0; i < 2; i++) begin
      can = !full[i] && !(m_wr_en[i] && afull[i]);
      g = -1;
      if (m_owner[i] < 0) begin
        if (can)
          for (int k = 0; k < NR; k++)
            if (g < 0 && v[(m_ptr[i] + k) % NR]) g = (m_ptr[i] + k) % NR;
      end else if (can && v[m_owner[i]]) begin
        g = m_owner[i];
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check_eq($sformatf("ready%0d", i), (i == 0) ? ready_a : ready_b, er);
      check_eq($sformatf("overflow%0d", i),
               ((i == 0) ? wr_en_a : wr_en_b) && (m_cnt[i] == DEPTH), 0);
      if (rd[i] && m_cnt[i] > 0) m_cnt[i]--;
      if (m_wr_en[i]) m_cnt[i]++;
      if (g >= 0) begin
        m_wr_en[i] = 1'b1;
        m_data[i]  = d[g*DW +: DW];
        m_gid[i]   = g;
        m_beats[i] = (m_owner[i] < 0) ? 1 : m_beats[i] + 1;
        if (m_owner[i] < 0 && mb[i] > 1) begin
          m_owner[i] = g; m_busy[i] = 1'b1;
        end else if (m_beats[i] == mb[i]) begin
          m_ptr[i] = (g + 1) % NR; m_owner[i] = -1; m_busy[i] = 1'b0;
        end
      end else begin
        m_wr_en[i] = 1'b0;
        if (m_owner[i] >= 0 && !v[m_owner[i]]) begin
          m_ptr[i] = (m_owner[i] + 1) % NR; m_owner[i] = -1; m_busy[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("wr_en_a", wr_en_a, m_wr_en[0]);
    check_eq("wr_en_b", wr_en_b, m_wr_en[1]);
    check_eq("busy_a", busy_a, m_busy[0]);
    check_eq("busy_b", busy_b, m_busy[1]);
    check_eq("data_a", wr_data_a, m_data[0]);
    check_eq("data_b", wr_data_b, m_data[1]);
    if (m_wr_en[0]) check_eq("gid_a", gid_a, m_gid[0]);
    if (m_wr_en[1]) check_eq("gid_b", gid_b, m_gid[1]);
    if (wr_en_a) wr_cnt[0]++;
    if (wr_en_b) wr_cnt[1]++;
    @(negedge clk);
  endtask

  initial begin
    logic [NR-1:0] v;
    apply_reset(2);

    // Single requester 2, three beats, then drop valid; next search starts at 3.
    rd_mode = 1; wr_cnt[0] = 0;
    cycle(4'b0100, lane(2, 8'h11), 1'b0);
    cycle(4'b0100, lane(2, 8'h22), 1'b0);
    cycle(4'b0100, lane(2, 8'h33), 1'b0);
    check_eq("t1_data_last", wr_data_a, 32'h33);
    cycle(4'b0000, '0, 1'b0);
    check_eq("t1_writes", wr_cnt[0], 3);
    cycle(4'b1001, lane(0, 8'hA0) | lane(3, 8'hB3), 1'b0);
    check_eq("t1_next_gid", gid_a, 3);
    cycle(4'b0000, '0, 1'b0);

    // All valid: per-beat rotation on B, 4-beat bursts back to back on A.
    apply_reset(1);
    for (int k = 0; k < 16; k++) begin
      cycle(4'b1111, {$urandom, 32'h0} >> 32, 1'b0);
      check_eq("t2_gid_b", gid_b, k % NR);
      check_eq("t3_gid_a", gid_a, (k / 4) % NR);
      check_eq("t3_wr_en_a", wr_en_a, 1);
    end
    cycle(4'b0000, '0, 1'b0);

    // No reads, req 1 streams: exactly DEPTH writes reach each FIFO.
    apply_reset(1);
    rd_mode = 0; wr_cnt[0] = 0; wr_cnt[1] = 0;
    for (int k = 0; k < 14; k++) cycle(4'b0010, lane(1, 8'(k + 1)), 1'b0);
    check_eq("t4_writes_a", wr_cnt[0], DEPTH);
    check_eq("t4_writes_b", wr_cnt[1], DEPTH);

    // Backpressure mid-burst of req 0 while req 3 waits.
    apply_reset(1);
    rd_mode = 1;
    for (int k = 0; k < 9; k++) begin
      cycle(4'b1001, lane(0, 8'(8'h40 + k)) | lane(3, 8'(8'h80 + k)), (k >= 2 && k < 5));
      if (k == 6) check_eq("t5_beat4_owner", gid_a, 0);
      if (k == 7) check_eq("t5_next_owner", gid_a, 3);
    end
    cycle(4'b0000, '0, 1'b0);

    // Reset during a burst at beat 2 clears outputs asynchronously.
    apply_reset(1);
    cycle(4'b0001, lane(0, 8'h5A), 1'b0);
    cycle(4'b0001, lane(0, 8'h5B), 1'b0);
    check_eq("t6_busy_before", busy_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1010, lane(1, 8'hC1) | lane(3, 8'hC3), 1'b0);
    check_eq("t6_first_gid", gid_a, 1);

    // Randomized traffic with random reads, forced full and occasional resets.
    rd_mode = 2;
    v = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) v = NR'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) begin
        apply_reset(1);
        rd_mode = 2;
      end
      cycle(v, {$urandom, 32'h0} >> 32, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
